// File: rtl/ram_arb_pkg.sv
// Shared types for the ram_sdp read-port arbiter: ID width helpers and the shadow-pipeline entry.
// ID field is sized for the largest supported requester count (16).
package ram_arb_pkg;

  localparam int ID_W_MAX = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

  typedef struct packed {
    logic                valid;
    logic [ID_W_MAX-1:0] id;
  } shadow_t;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot request arbiter: round-robin from ptr when RAM_RD_ARB_RR_EN is defined, else lowest index wins.
// Purely combinational; grants nothing when no request is present.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
`ifdef RAM_RD_ARB_RR_EN
  input  logic [PW-1:0] ptr,
`endif
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_id
);

  always_comb begin
    int   idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    gnt    = '0;
    gnt_id = '0;
    for (int k = 0; k < N; k++) begin
`ifdef RAM_RD_ARB_RR_EN
      idx = (int'(ptr) + k) % N;
`else
      idx = k;
`endif
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/ram_rd_arb.sv
// Shares one ram_sdp read port among NUM_REQ clients; round-robin with RAM_RD_ARB_RR_EN, else fixed priority.
// Accept-to-response latency DOUT_PIPE_NUMBER+3; one accept per cycle, responses cannot be backpressured.
module ram_rd_arb
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int ADDR_WIDTH       = 14,
  parameter int DATA_WIDTH       = 36,
  parameter int DOUT_PIPE_NUMBER = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          enb,
  output logic [ADDR_WIDTH-1:0]         addrb,
  input  logic [DATA_WIDTH-1:0]         doutb,
  input  logic                          doutb_valid,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err
);

  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_id;
  logic                accept;
  logic [ID_W_MAX-1:0] id_q;
  shadow_t             sh [DOUT_PIPE_NUMBER+1];
  shadow_t             sh_exit;

`ifdef RAM_RD_ARB_RR_EN
  logic [ID_W-1:0] ptr;

  rr_arbiter #(.N(NUM_REQ), .PW(ID_W)) u_arb (
    .ptr    (ptr),
    .req    (req_valid),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + ID_W'(1);
    end
  end
`else
  rr_arbiter #(.N(NUM_REQ), .PW(ID_W)) u_arb (
    .req    (req_valid),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );
`endif

  assign req_ready = rst_n ? gnt : '0;
  assign accept    = |req_ready;

  // The ID travels next to enb so that stage 0 captures it on the same edge the RAM samples enb.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enb   <= 1'b0;
      addrb <= '0;
      id_q  <= '0;
    end else begin
      enb  <= accept;
      id_q <= ID_W_MAX'(gnt_id);
      if (accept) addrb <= req_addr[int'(gnt_id)*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k <= DOUT_PIPE_NUMBER; k++) sh[k] <= '0;
    end else begin
      sh[0] <= '{valid: enb, id: id_q};
      for (int k = 1; k <= DOUT_PIPE_NUMBER; k++) sh[k] <= sh[k-1];
    end
  end

  assign sh_exit = sh[DOUT_PIPE_NUMBER];

  // ram_sdp is never reset, so a read issued before reset can still return; flag it instead of routing it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_data  <= doutb;
      rsp_err   <= sh_exit.valid != doutb_valid;
      rsp_valid <= (sh_exit.valid && doutb_valid) ? (NUM_REQ'(1) << sh_exit.id) : '0;
    end
  end

endmodule

// File: tb/tb_ram_rd_arb.sv
// Bench for ram_rd_arb with a non-resetting ram_sdp read-port model and a cycle-indexed response scoreboard.
module tb_ram_rd_arb;

  localparam int NR  = 4;
  localparam int AW  = 14;
  localparam int DW  = 36;
  localparam int DPN = 10;
  localparam int LAT = DPN + 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NR-1:0]  req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]  req_ready;
  logic           enb;
  logic [AW-1:0]  addrb;
  logic [DW-1:0]  doutb;
  logic           doutb_valid;
  logic [NR-1:0]  rsp_valid;
  logic [DW-1:0]  rsp_data;
  logic           rsp_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit sb_en  = 1'b0;

  always #5 clk = ~clk;

  ram_rd_arb #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DOUT_PIPE_NUMBER(DPN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .enb         (enb),
    .addrb       (addrb),
    .doutb       (doutb),
    .doutb_valid (doutb_valid),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err)
  );

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    logic [AW-1:0] m;
    m = a ^ 14'h2A;
    return {m[7:0], 14'h0, a};
  endfunction

  // RAM read port: enb sampled, data/valid emerge DPN+1 edges later; no reset.
  logic          pv [DPN+1];
  logic [DW-1:0] pd [DPN+1];
  initial for (int k = 0; k <= DPN; k++) begin pv[k] = 1'b0; pd[k] = '0; end
  always @(posedge clk) begin
    pv[0] <= (enb === 1'b1);
    pd[0] <= ram_word(addrb);
    for (int k = 1; k <= DPN; k++) begin pv[k] <= pv[k-1]; pd[k] <= pd[k-1]; end
  end
  assign doutb_valid = pv[DPN];
  assign doutb       = pd[DPN];

  always @(posedge clk) cyc <= cyc + 1;

  // Expectations keyed by the cycle in which the output should be visible.
  logic [NR-1:0] exp_vld  [int];
  logic [DW-1:0] exp_dat  [int];
  bit            exp_err  [int];
  logic [AW-1:0] exp_addr [int];
  bit            zero_chk [int];
`ifdef RAM_RD_ARB_RR_EN
  int mptr = 0;
`endif

  always @(negedge clk) begin
    int            g, idx;
    int            ks[$];
    logic [NR-1:0] mg, ev;
    logic [AW-1:0] a;
    bit            ee;
    if (rst_n !== 1'b1) begin
      checks++;
      if (req_ready !== '0) begin errors++; $display("FAIL sb_ready_in_reset cyc=%0d got=%b exp=0", cyc, req_ready); end
      ks = {};
      foreach (exp_vld[k]) if (k > cyc) ks.push_back(k);
      foreach (ks[j]) begin
        if (ks[j] > cyc + 1) exp_err[ks[j]] = 1'b1;
        exp_vld.delete(ks[j]);
        exp_dat.delete(ks[j]);
      end
      if (exp_err.exists(cyc + 1)) exp_err.delete(cyc + 1);
`ifdef RAM_RD_ARB_RR_EN
      mptr = 0;
`endif
      zero_chk[cyc + 1] = 1'b1;
    end else begin
      g = -1;
      for (int k = 0; k < NR; k++) begin
`ifdef RAM_RD_ARB_RR_EN
        idx = (mptr + k) % NR;
`else
        idx = k;
`endif
        if (g < 0 && req_valid[idx]) g = idx;
      end
      mg = (g >= 0) ? (NR'(1) << g) : '0;
      checks++;
      if (req_ready !== mg) begin errors++; $display("FAIL sb_grant cyc=%0d got=%b exp=%b", cyc, req_ready, mg); end
      if (g >= 0) begin
        a = req_addr[g*AW +: AW];
        exp_addr[cyc + 1]  = a;
        exp_vld[cyc + LAT] = mg;
        exp_dat[cyc + LAT] = ram_word(a);
`ifdef RAM_RD_ARB_RR_EN
        mptr = (g + 1) % NR;
`endif
      end
    end
    if (sb_en) begin
      ev = exp_vld.exists(cyc) ? exp_vld[cyc] : '0;
      ee = exp_err.exists(cyc);
      checks++;
      if (rsp_valid !== ev) begin errors++; $display("FAIL sb_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, ev); end
      if (ev != '0) begin
        checks++;
        if (rsp_data !== exp_dat[cyc]) begin errors++; $display("FAIL sb_rsp_data cyc=%0d got=%h exp=%h", cyc, rsp_data, exp_dat[cyc]); end
      end
      checks++;
      if (rsp_err !== ee) begin errors++; $display("FAIL sb_rsp_err cyc=%0d got=%b exp=%b", cyc, rsp_err, ee); end
      checks++;
      if (enb !== exp_addr.exists(cyc)) begin errors++; $display("FAIL sb_enb cyc=%0d got=%b exp=%b", cyc, enb, exp_addr.exists(cyc)); end
      if (exp_addr.exists(cyc)) begin
        checks++;
        if (addrb !== exp_addr[cyc]) begin errors++; $display("FAIL sb_addrb cyc=%0d got=%h exp=%h", cyc, addrb, exp_addr[cyc]); end
      end
      if (zero_chk.exists(cyc)) begin
        checks++;
        if (rsp_data !== '0 || addrb !== '0) begin errors++; $display("FAIL sb_reset_regs cyc=%0d data=%h addrb=%h exp=0", cyc, rsp_data, addrb); end
      end
    end
    if (exp_vld.exists(cyc))  exp_vld.delete(cyc);
    if (exp_dat.exists(cyc))  exp_dat.delete(cyc);
    if (exp_err.exists(cyc))  exp_err.delete(cyc);
    if (exp_addr.exists(cyc)) exp_addr.delete(cyc);
    if (zero_chk.exists(cyc)) zero_chk.delete(cyc);
  end

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '1; req_addr = '0;
    @(negedge clk);
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; req_valid = '0; sb_en = 1'b1;
    @(negedge clk);
    checks++;
    if (enb !== 1'b0 || addrb !== '0) begin errors++; $display("FAIL reset_issue enb=%b addrb=%h exp=0", enb, addrb); end
    checks++;
    if (rsp_valid !== '0 || rsp_data !== '0 || rsp_err !== 1'b0)
      begin errors++; $display("FAIL reset_rsp vld=%b data=%h err=%b exp=0", rsp_valid, rsp_data, rsp_err); end
  endtask

  task automatic test_single();
    int t_acc = -1, t_rsp = -1;
    @(posedge clk); #1;
    req_valid = 4'b0100; req_addr[2*AW +: AW] = 14'h15;
    for (int k = 0; k < 10 && t_acc < 0; k++) begin
      @(negedge clk);
      if (req_ready[2]) t_acc = cyc;
      @(posedge clk); #1;
      if (t_acc >= 0) req_valid = '0;
    end
    req_valid = '0;
    for (int k = 0; k < 40 && t_acc >= 0; k++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        t_rsp = cyc;
        checks++;
        if (rsp_valid !== 4'b0100 || rsp_data !== ram_word(14'h15))
          begin errors++; $display("FAIL single_rsp vld=%b data=%h exp=0100/%h", rsp_valid, rsp_data, ram_word(14'h15)); end
        break;
      end
    end
    checks++;
    if (t_acc < 0 || t_rsp - t_acc != LAT)
      begin errors++; $display("FAIL single_latency acc=%0d rsp=%0d exp_lat=%0d", t_acc, t_rsp, LAT); end
  endtask

  task automatic test_contention();
    int cnt[NR];
    int seq[$];
    logic [NR-1:0] gv;
    bit ok;
    for (int i = 0; i < NR; i++) cnt[i] = 0;
    repeat (LAT + 3) @(posedge clk); #1;
    req_valid = '1;
    for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = AW'($urandom);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      gv = req_ready;
      for (int i = 0; i < NR; i++) if (gv[i]) begin cnt[i]++; seq.push_back(i); end
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) if (gv[i]) req_addr[i*AW +: AW] = AW'($urandom);
    end
    req_valid = '0;
    checks++;
    if (seq.size() != 8) begin errors++; $display("FAIL contention_grants got=%0d exp=8", seq.size()); end
`ifdef RAM_RD_ARB_RR_EN
    for (int i = 0; i < NR; i++) begin
      checks++;
      if (cnt[i] != 2) begin errors++; $display("FAIL contention_share req=%0d got=%0d exp=2", i, cnt[i]); end
    end
    ok = 1'b1;
    for (int j = 1; j < seq.size(); j++) if (seq[j] != (seq[j-1] + 1) % NR) ok = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL contention_order got=%p exp=rotating", seq); end
`else
    ok = 1'b1;
    checks++;
    if (cnt[0] != 8) begin errors++; $display("FAIL contention_fixed got=%0d exp=8", cnt[0]); end
`endif
  endtask

  task automatic test_back_to_back();
    repeat (LAT + 3) @(posedge clk); #1;
    fork
      begin
        int n_acc = 0, c = 0;
        logic acc;
        req_valid[0] = 1'b1; req_addr[0 +: AW] = '0;
        while (n_acc < 16 && c < 40) begin
          @(negedge clk); acc = req_ready[0];
          @(posedge clk); #1; c++;
          if (acc) begin
            n_acc++;
            req_addr[0 +: AW] = AW'(n_acc);
            if (n_acc == 16) req_valid[0] = 1'b0;
          end
        end
        req_valid[0] = 1'b0;
        checks++;
        if (n_acc != 16 || c != 16) begin errors++; $display("FAIL b2b_accepts got=%0d in %0d cycles exp=16 in 16", n_acc, c); end
      end
      begin
        bit seen = 1'b0;
        int w = 0;
        while (!seen && w < 80) begin @(negedge clk); w++; if (rsp_valid[0]) seen = 1'b1; end
        checks++;
        if (!seen) begin errors++; $display("FAIL b2b_timeout got=no response exp=response"); end
        else begin
          for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (rsp_valid !== 4'b0001 || rsp_data !== ram_word(AW'(i)))
              begin errors++; $display("FAIL b2b_rsp idx=%0d vld=%b data=%h exp=0001/%h", i, rsp_valid, rsp_data, ram_word(AW'(i))); end
          end
        end
      end
    join
  endtask

  task automatic test_fixed_prio();
    int c0 = 0, c3 = 0;
    logic [NR-1:0] gv;
    repeat (LAT + 3) @(posedge clk); #1;
    req_valid = 4'b1001;
    req_addr[0 +: AW] = AW'($urandom); req_addr[3*AW +: AW] = AW'($urandom);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); gv = req_ready;
      if (gv[0]) c0++;
      if (gv[3]) c3++;
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) if (gv[i]) req_addr[i*AW +: AW] = AW'($urandom);
    end
    req_valid = '0;
`ifdef RAM_RD_ARB_RR_EN
    checks++;
    if (c0 + c3 != 5 || c0 - c3 > 1 || c3 - c0 > 1)
      begin errors++; $display("FAIL prio_rr got=%0d/%0d exp=alternating", c0, c3); end
`else
    checks++;
    if (c0 != 5) begin errors++; $display("FAIL prio_fixed_req0 got=%0d exp=5", c0); end
    checks++;
    if (c3 != 0) begin errors++; $display("FAIL prio_fixed_req3 got=%0d exp=0", c3); end
`endif
  endtask

  task automatic test_random();
    logic [NR-1:0] gv;
    repeat (LAT + 3) @(posedge clk); #1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      gv = req_ready;
      checks++;
      if ((|req_valid) !== (|req_ready)) begin errors++; $display("FAIL random_work cyc=%0d vld=%b rdy=%b", cyc, req_valid, req_ready); end
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (gv[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 99) < 45);
          req_addr[i*AW +: AW] = AW'($urandom);
        end
      end
    end
    req_valid = '0;
  endtask

  task automatic test_reset_midflight();
    int n = 0, c = 0, n_err = 0, n_vld = 0;
    logic acc;
    repeat (LAT + 3) @(posedge clk); #1;
    req_valid = 4'b0010; req_addr[AW +: AW] = 14'h100;
    while (n < 4 && c < 20) begin
      @(negedge clk); acc = req_ready[1];
      @(posedge clk); #1; c++;
      if (acc) begin
        n++;
        req_addr[AW +: AW] = AW'(14'h100 + n * 7);
        if (n == 4) req_valid = '0;
      end
    end
    req_valid = '0;
    checks++;
    if (n != 4) begin errors++; $display("FAIL midflight_accepts got=%0d exp=4", n); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0; req_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if (req_ready !== '0) begin errors++; $display("FAIL midflight_ready got=%b exp=0", req_ready); end
    @(posedge clk);
    #1 rst_n = 1'b1; req_valid = '0;
    @(negedge clk);
    checks++;
    if (enb !== 1'b0 || addrb !== '0 || rsp_valid !== '0 || rsp_data !== '0 || rsp_err !== 1'b0)
      begin errors++; $display("FAIL midflight_cleared enb=%b addrb=%h vld=%b data=%h err=%b exp=0", enb, addrb, rsp_valid, rsp_data, rsp_err); end
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (rsp_err) n_err++;
      if (|rsp_valid) n_vld++;
    end
    checks++;
    if (n_err != 4) begin errors++; $display("FAIL midflight_err got=%0d exp=4", n_err); end
    checks++;
    if (n_vld != 0) begin errors++; $display("FAIL midflight_valid got=%0d exp=0", n_vld); end
  endtask

  task automatic test_idle();
    repeat (LAT + 3) @(posedge clk);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      checks++;
      if (enb !== 1'b0 || rsp_valid !== '0 || rsp_err !== 1'b0)
        begin errors++; $display("FAIL idle cyc=%0d enb=%b vld=%b err=%b exp=0", cyc, enb, rsp_valid, rsp_err); end
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_addr = '0;
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_fixed_prio();
    test_random();
    test_reset_midflight();
    test_idle();
    repeat (LAT + 3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
